jk_seq_ctrl: RTL and testbench
==============================

// Module: jk_seq_ctrl
// PURPOSE
//  Sequencer for the 2-bit JK state machine (state {A,B}; Ja=B, Ka=~A&B, Jb=A, Kb=A).
//  Accepts a command with valid/ready: load an initial state, then advance the JK flops N steps.
//  Supports hold (pause) and abort. Reports progress and pulses done.
//  Sits between a test/host controller and the JK state register; owns the flops and their clocking.
// PARAMETERS
//  CNT_W    8    width of step count fields (max run = 2**CNT_W-1 steps)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      controller can accept command (high only in IDLE)
//  cmd_init     in   2      initial state {A,B} loaded on accept
//  cmd_steps    in   CNT_W  number of JK steps to run
//  hold         in   1      freeze the run (no step, no count) while high
//  abort        in   1      terminate the run early
//  state        out  2      current {A,B}
//  ja,ka,jb,kb  out  1 each excitation for current state (combinational from state)
//  steps_done   out  CNT_W  steps applied in current/last run
//  busy         out  1      high in RUN and DONE
//  done         out  1      one-cycle pulse at end of run
//  stalled      out  1      stall flag (feature below; else constant 0)
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE, state=00, remain=0, steps_done=0, done=0, busy=0, stalled=0;
//   cmd_ready=1 while in reset, because it is decoded from IDLE.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: cmd_ready=1. Handshake: accept on the edge where cmd_valid&&cmd_ready.
//   On accept: state<=cmd_init, remain<=cmd_steps, steps_done<=0, stalled<=0.
//   Next state is DONE if cmd_steps==0 (no step applied), otherwise RUN.
//  RUN: cmd_ready=0, so commands are ignored and not queued. Priority per edge: abort > hold > step.
//   abort=1: go to DONE; no step is applied; steps_done is kept.
//   hold=1 (abort=0): state, remain and steps_done are all frozen.
//   Step: each flop takes its JK update (00 hold, 01 reset, 10 set, 11 toggle); remain--, steps_done++.
//   On the step where remain==1, go to DONE.
//  DONE: done=1 for exactly one cycle, then IDLE. hold, abort and cmd_valid are ignored.
//  Latency: accept at edge k with N>0 and no hold gives steps at edges k+1..k+N.
//   done is high from k+N to k+N+1. cmd_ready returns at k+N+1.
//   Each held cycle adds one cycle.
//  Sequences under these equations: 00->00 (fixed point); 01->11->10->11->10...
//  steps_done never wraps because it is bounded by cmd_steps.
//  abort in IDLE has no effect. state holds its value between runs.
// CONFIGURATION
//  STALL_DETECT_EN defined: in RUN, a step whose next state equals the current state
//   is applied and counted, sets stalled=1, and goes to DONE.
//   stalled stays high until the next accepted command.
//  STALL_DETECT_EN undefined: stalled tied 0; the run always completes cmd_steps steps.
// TESTING
//  1. init=01, steps=4 -> state 11,10,11,10 on edges k+1..k+4; done pulse one cycle; steps_done=4.
//  2. init=10, steps=0 -> no step; done on next cycle; state=10; steps_done=0.
//  3. init=01, steps=3, hold high 3 cycles after 1st step -> state frozen at 11; done 3 cycles late; final 11.
//  4. init=00, steps=5 -> with STALL_DETECT_EN: done after 1 step, stalled=1, steps_done=1.
//     Without it: 5 steps, state 00, stalled=0.
//  5. cmd_valid pulsed in RUN -> ignored; abort with hold after 2 steps -> DONE next edge, steps_done=2.
//  6. rst_n low mid-RUN -> outputs at reset values asynchronously, cmd_ready=1; new command accepted after release.

Source files
------------

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: valid/ready sequencer stepping a 2-bit JK state machine {A,B} with hold, abort and done pulse.
// Optional STALL_DETECT_EN ends a run on a step that leaves the state unchanged and flags stalled.
module jk_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_init,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             hold,
  input  logic             abort,
  output logic [1:0]       state,
  output logic             ja,
  output logic             ka,
  output logic             jb,
  output logic             kb,
  output logic [CNT_W-1:0] steps_done,
  output logic             busy,
  output logic             done,
  output logic             stalled
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;
  fsm_t fsm, fsm_nxt;
  logic [CNT_W-1:0] remain;
  logic [1:0] nxt;
  logic accept, step, stall_hit;
  always_comb begin
    ja = state[0];
    ka = ~state[1] & state[0];
    jb = state[1];
    kb = state[1];
    nxt = {ja & ~state[1] | ~ka & state[1], jb & ~state[0] | ~kb & state[0]};
    accept = cmd_valid && cmd_ready;
    step = fsm == S_RUN && !abort && !hold;
  end
`ifdef STALL_DETECT_EN
  assign stall_hit = step && nxt == state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stalled <= 1'b0;
    else if (accept) stalled <= 1'b0;
    else if (stall_hit) stalled <= 1'b1;
`else
  assign stall_hit = 1'b0;
  assign stalled = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fsm <= S_IDLE;
    else fsm <= fsm_nxt;
  always_comb
    fsm_nxt = fsm == S_IDLE ? (accept ? (cmd_steps == '0 ? S_DONE : S_RUN) : S_IDLE) :
              fsm == S_RUN  ? (abort || (step && (remain == CNT_W'(1) || stall_hit)) ? S_DONE : S_RUN) :
                              S_IDLE;
  always_comb begin
    cmd_ready = fsm == S_IDLE;
    busy = fsm == S_RUN || fsm == S_DONE;
    done = fsm == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= 2'b00;
      remain <= '0;
      steps_done <= '0;
    end else if (accept) begin
      state <= cmd_init;
      remain <= cmd_steps;
      steps_done <= '0;
    end else if (step) begin
      state <= nxt;
      remain <= remain - CNT_W'(1);
      steps_done <= steps_done + CNT_W'(1);
    end
endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: scoreboard bench; a JK truth-table model predicts every busy cycle, a monitor pops and compares.
module tb_jk_seq_ctrl;
  localparam int CNT_W = 8;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [1:0] cmd_init = 2'b00;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic cmd_ready, ja, ka, jb, kb, busy, done, stalled;
  logic [1:0] state;
  logic [CNT_W-1:0] steps_done;
  typedef struct packed {
    logic [1:0]       st;
    logic [CNT_W-1:0] sd;
    logic             stl;
    logic             dn;
  } exp_t;
  exp_t exp_q[$];
  logic [1:0] sched_q[$];
  int tests = 0, fails = 0;
  bit mon_en = 1'b0;
  jk_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_init(cmd_init), .cmd_steps(cmd_steps), .hold(hold), .abort(abort),
    .state(state), .ja(ja), .ka(ka), .jb(jb), .kb(kb), .steps_done(steps_done),
    .busy(busy), .done(done), .stalled(stalled)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // JK flop truth table: 00 hold, 01 reset, 10 set, 11 toggle
  function automatic logic jk(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00: return q;
      2'b01: return 1'b0;
      2'b10: return 1'b1;
      default: return ~q;
    endcase
  endfunction
  function automatic logic [1:0] jk_next(input logic [1:0] s);
    logic a, b;
    a = s[1];
    b = s[0];
    return {jk(a, b, ~a & b), jk(b, a, a)};
  endfunction
  task automatic push(input logic [1:0] s, input int d, input bit t, input bit f);
    exp_t e;
    e.st = s;
    e.sd = CNT_W'(d);
    e.stl = t;
    e.dn = f;
    exp_q.push_back(e);
  endtask
  // Called aligned 2 time units after a rising edge while the DUT is idle.
  task automatic run_cmd(input logic [1:0] init, input int n, input int hold_pct, input int abort_pct,
                         input int hold_at, input int hold_len, input int abort_at);
    logic [1:0] st, nx;
    int sd, rem, i;
    bit h, a, stl, fin;
    st = init;
    sd = 0;
    rem = n;
    i = 0;
    stl = 1'b0;
    fin = n == 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    push(init, 0, 1'b0, fin);
    while (!fin) begin
      h = (i >= hold_at && i < hold_at + hold_len) || $urandom_range(99) < hold_pct;
      a = i == abort_at || $urandom_range(99) < abort_pct;
      sched_q.push_back({h, a});
      i++;
      if (a) fin = 1'b1;
      else if (!h) begin
        nx = jk_next(st);
        sd++;
        rem--;
`ifdef STALL_DETECT_EN
        if (nx == st) begin
          stl = 1'b1;
          fin = 1'b1;
        end
`endif
        st = nx;
        if (rem == 0) fin = 1'b1;
      end
      push(st, sd, stl, fin);
    end
    cmd_valid = 1'b1;
    cmd_init = init;
    cmd_steps = CNT_W'(n);
    hold = 1'($urandom_range(1));
    abort = 1'($urandom_range(1));
    @(posedge clk); #2;
    while (sched_q.size() != 0) begin
      {hold, abort} = sched_q.pop_front();
      cmd_valid = 1'($urandom_range(1));
      cmd_init = 2'($urandom);
      cmd_steps = CNT_W'($urandom);
      chk("cmd_ready_run", cmd_ready, 0);
      @(posedge clk); #2;
    end
    chk("cmd_ready_done", cmd_ready, 0);
    cmd_valid = 1'($urandom_range(1));
    hold = 1'($urandom_range(1));
    abort = 1'($urandom_range(1));
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    hold = 1'b0;
    abort = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat ($urandom_range(2)) begin
      abort = 1'($urandom_range(1));
      @(posedge clk); #2;
    end
    abort = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (busy || done)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_busy: got busy=%0b done=%0b expected idle at %0t", busy, done, $time);
      end else begin
        e = exp_q.pop_front();
        chk("state", state, e.st);
        chk("steps_done", steps_done, e.sd);
        chk("stalled", stalled, e.stl);
        chk("done", done, e.dn);
      end
    end
  end
  initial begin
    #3;
    chk("rst_state", state, 0);
    chk("rst_steps_done", steps_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_cmd(2'b01, 4, 0, 0, -1, 0, -1);
    run_cmd(2'b10, 0, 0, 0, -1, 0, -1);
    run_cmd(2'b01, 3, 0, 0, 1, 3, -1);
    run_cmd(2'b00, 5, 0, 0, -1, 0, -1);
    run_cmd(2'b01, 6, 0, 0, 2, 1, 2);
    run_cmd(2'b11, 255, 0, 0, -1, 0, -1);
    for (int k = 0; k < 150; k++)
      run_cmd(2'($urandom), $urandom_range(9) == 0 ? int'($urandom_range(255)) : int'($urandom_range(12)),
              20, 3, -1, 0, -1);
    mon_en = 1'b0;
    cmd_valid = 1'b1;
    cmd_init = 2'b01;
    cmd_steps = CNT_W'(40);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_state", state, 2'b11);
    chk("pre_reset_steps", steps_done, 3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_steps_done", steps_done, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    chk("async_rst_stalled", stalled, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_cmd(2'b01, 4, 0, 0, -1, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
